psum_ofifo: RTL and testbench
=============================

# psum_ofifo

Output collection buffer directly downstream of `mac_array`. It accepts the per-column 22-bit partial sums that `mac_array` emits independently per column under `fifo_wr[c]`, and realigns them into full rows. It presents a row only when every column holds at least one entry, and pops all columns together on a read. It feeds the SRAM write-back / normalization stage.

## Interface
- `col`, 8, number of MAC columns (lanes)
- `bw_psum`, 22, psum width per lane
- `depth`, 16, entries per lane; power of two, ≥ 2
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- `in`  in  col*bw_psum  psums from `mac_array.out`; lane c = `in[bw_psum*(c+1)-1 : bw_psum*c]`
- `wr`  in  col  per-lane write strobes from `mac_array.fifo_wr`
- `rd`  in  1  row read request
- `out`  out  col*bw_psum  registered row data, same lane packing as `in`
- `o_valid`  out  1  every lane non-empty (a row is available)
- `o_full`  out  1  any lane full
- `o_ready`  out  1  = !o_full
- `o_out_vld`  out  1  `out` holds a freshly popped row this cycle
- `o_overflow`  out  col  sticky per-lane drop flag

## Operation
- Each lane is an independent circular FIFO with `depth` entries.
  - Write pointer and read pointer are each log2(depth) bits.
  - Count is log2(depth)+1 bits, range 0..depth.
  - Pointers wrap from depth-1 to 0.
- **Write, lane c:** if `wr[c]` and (count_c < depth, or a pop occurs on the same edge):
  - store `in` lane c at wr_ptr_c;
  - increment wr_ptr_c.
- **Write to a full lane with no simultaneous pop:** the data is dropped, `o_overflow[c]` is set, and pointers and count are unchanged.
- **Pop:** a pop is accepted when `rd && o_valid`, with `o_valid` evaluated from pre-edge counts. An accepted pop:
  - reads the head of all lanes;
  - loads the head values into `out`;
  - increments every rd_ptr.
- `rd` while `!o_valid` is ignored: no pointer movement, `out` holds, `o_out_vld`=0.
- **Count update per lane:** +1 on an accepted write without a pop, −1 on a pop without a write, unchanged when both or neither occur.
- **Write and pop on the same lane, same edge:**
  - at count=depth, the write is accepted and count stays depth;
  - at count=1, the pop returns the old head and count stays 1.
- **Flags:**
  - `o_valid` = AND over lanes of (count≠0);
  - `o_full` = OR over lanes of (count==depth);
  - all flags are combinational from registered counts.
- Data is stored unsigned/raw; the block applies no arithmetic or sign handling.
- `o_overflow` clears only on reset.

## Timing
- Reset values:
  - all pointers and counts = 0;
  - `out` = 0, `o_out_vld` = 0, `o_overflow` = 0;
  - hence `o_valid` = 0, `o_full` = 0, `o_ready` = 1.
- Reset mid-operation discards all stored entries immediately, asynchronously.
- **Write-to-flag latency:** a write at edge N makes count visible after edge N. `o_valid` can therefore rise in the cycle following the last-arriving lane's write.
- **Read latency:** 1 cycle. `rd` sampled at edge N loads `out` at edge N, with `o_out_vld`=1 in the cycle after N only.
- **Back-to-back pops:** `rd` held high with `o_valid` high pops one row per cycle.
- Stored rows are unaffected by skew between lanes: `mac_array` columns write on different cycles (diagonal wavefront).
- Memory is flop-based, with a synchronous write and the read mux taken from the registered rd_ptr.

## Structure
- Shared package `mac_pkg`:
  - default `COL`=8, `BW_PSUM`=22, `OFIFO_DEPTH`=16;
  - `inst` encodings shared with `mac_array` (2'b01 load K, 2'b10 execute, 2'b00 idle);
  - `psum_t` typedef of bw_psum bits.
- Sub-module `psum_fifo_lane`: one bw_psum × depth FIFO with ports wr, rd, din, dout, count, full, empty. It is instantiated `col` times via generate.
- The top level holds the AND/OR flag reduction, pop qualification, `out`/`o_out_vld` registers and overflow flags.

## Test plan
- **Reset state:** assert `reset`=0 mid-stream after 3 rows are written, then release.
  - Expect `o_valid`=0, `o_ready`=1, `out`=0, `o_overflow`=0.
  - `rd` then produces no `o_out_vld`.
- **Skewed write, single row:** write value 100+c to lane c at cycle c (c=0..7).
  - Expect `o_valid` low until the cycle after the lane 7 write.
  - `rd` → next cycle `out` lane c = 100+c, `o_out_vld`=1 for exactly one cycle, `o_valid`=0 afterwards.
- **mac_array end-to-end:** 8 K and 8 Q vectors from kdata/qdata, loaded with inst=01, executed with inst=10, `rd` tied high.
  - Expect 8 `o_out_vld` pulses.
  - Row q lane k = Σ Q[q][i]·K[k][i] (22-bit), matching the bench prediction.
- **Full and overflow:** write 17 rows with no reads.
  - `o_full`=1 after row 16.
  - The 17th write sets `o_overflow`=8'hFF.
  - Subsequent reads return rows 0..15 in order; row 16 is never seen.
- **Simultaneous read/write when full:** with all lanes at count=16, pulse `wr`=8'hFF (value 555) together with `rd`.
  - Row 0 is popped; count stays 16; no overflow.
  - Draining yields 555 as the last row.
- **Wrap-around:** 40 write/read cycles at steady occupancy 3.
  - Data order is preserved across pointer wrap (15→0), checked against a scoreboard.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC array and its output collection buffer.
package mac_pkg;

   localparam int unsigned COL         = 8;
   localparam int unsigned BW_PSUM     = 22;
   localparam int unsigned OFIFO_DEPTH = 16;

   // Instruction encodings shared with mac_array.
   typedef enum logic [1:0] {
      InstIdle  = 2'b00,
      InstLoadK = 2'b01,
      InstExec  = 2'b10
   } inst_e;

   typedef logic [BW_PSUM-1:0] psum_t;

endpackage

// File: rtl/psum_fifo_lane.sv
// One psum lane: flop-based circular FIFO with occupancy count.
// 'rd' is an already-qualified pop; the top only asserts it when every lane is non-empty.
module psum_fifo_lane #(
   parameter int unsigned bw_psum = 22,
   parameter int unsigned depth   = 16,
   localparam int unsigned PtrW   = $clog2(depth),
   localparam int unsigned CntW   = PtrW + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr,
   input  logic               rd,
   input  logic [bw_psum-1:0] din,
   output logic [bw_psum-1:0] dout,
   output logic [CntW-1:0]    count,
   output logic               full,
   output logic               empty
);

   logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [bw_psum-1:0] mem_q [depth];
   logic               wr_ok;

   assign full  = (cnt_q == CntW'(depth));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;
   assign dout  = mem_q[rd_ptr_q];

   // A full lane still accepts a write when a pop frees its head on the same edge.
   assign wr_ok = wr && (!full || rd);

   // Next-state pointers and count; pointers wrap naturally at the power-of-two depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (rd)    rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({wr_ok, rd})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer and count state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/psum_ofifo.sv
// Realigns skewed per-column psums from mac_array into full rows for write-back.
module psum_ofifo
   import mac_pkg::*;
#(
   parameter int unsigned col     = COL,
   parameter int unsigned bw_psum = BW_PSUM,
   parameter int unsigned depth   = OFIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [col*bw_psum-1:0] in,
   input  logic [col-1:0]         wr,
   input  logic                   rd,
   output logic [col*bw_psum-1:0] out,
   output logic                   o_valid,
   output logic                   o_full,
   output logic                   o_ready,
   output logic                   o_out_vld,
   output logic [col-1:0]         o_overflow
);

   localparam int unsigned CntW = $clog2(depth) + 1;

   logic [bw_psum-1:0]     head [col];
   logic [CntW-1:0]        count [col];
   logic [col-1:0]         full, empty, drop;
   logic [col*bw_psum-1:0] row, out_q, out_d;
   logic                   pop, out_vld_q;
   logic [col-1:0]         overflow_q, overflow_d;

   for (genvar c = 0; c < col; c++) begin : g_lane
      psum_fifo_lane #(
         .bw_psum(bw_psum),
         .depth  (depth)
      ) u_lane (
         .clk  (clk),
         .reset(reset),
         .wr   (wr[c]),
         .rd   (pop),
         .din  (in[bw_psum*c +: bw_psum]),
         .dout (head[c]),
         .count(count[c]),
         .full (full[c]),
         .empty(empty[c])
      );
   end

   assign o_valid = &(~empty);
   assign o_full  = |full;
   assign o_ready = !o_full;
   assign pop     = rd && o_valid;

   // Pack lane heads into a row, qualify output load and per-lane drops.
   always_comb begin
      row = '0;
      for (int c = 0; c < col; c++) begin
         row[bw_psum*c +: bw_psum] = head[c];
         drop[c] = wr[c] && (count[c] == CntW'(depth)) && !pop;
      end
      out_d      = pop ? row : out_q;
      overflow_d = overflow_q | drop;
   end

   // Output row register, fresh-row strobe and sticky overflow flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q      <= '0;
         out_vld_q  <= 1'b0;
         overflow_q <= '0;
      end else begin
         out_q      <= out_d;
         out_vld_q  <= pop;
         overflow_q <= overflow_d;
      end
   end

   assign out        = out_q;
   assign o_out_vld  = out_vld_q;
   assign o_overflow = overflow_q;

endmodule

// File: tb/tb_psum_ofifo.sv
// Self-checking bench for psum_ofifo against a queue-based reference model.
module tb_psum_ofifo;

   localparam int NC = 8;
   localparam int BW = 22;
   localparam int DP = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [NC*BW-1:0] din = '0;
   logic [NC-1:0]    wr = '0;
   logic             rd = 1'b0;
   logic [NC*BW-1:0] dout;
   logic             o_valid, o_full, o_ready, o_out_vld;
   logic [NC-1:0]    o_overflow;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   // Reference model state
   logic [BW-1:0]    mq [NC][$];
   logic [NC*BW-1:0] exp_out = '0;
   logic             exp_vld = 1'b0;
   logic [NC-1:0]    exp_ovf = '0;

   psum_ofifo u_dut (
      .clk       (clk),
      .reset     (reset),
      .in        (din),
      .wr        (wr),
      .rd        (rd),
      .out       (dout),
      .o_valid   (o_valid),
      .o_full    (o_full),
      .o_ready   (o_ready),
      .o_out_vld (o_out_vld),
      .o_overflow(o_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [NC*BW-1:0] act, input logic [NC*BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [NC*BW-1:0] row_val(input int base);
      logic [NC*BW-1:0] r;
      for (int c = 0; c < NC; c++) r[c*BW +: BW] = BW'(base + c);
      return r;
   endfunction

   function automatic logic [NC*BW-1:0] row_const(input int v);
      logic [NC*BW-1:0] r;
      for (int c = 0; c < NC; c++) r[c*BW +: BW] = BW'(v);
      return r;
   endfunction

   function automatic logic [NC*BW-1:0] row_rand();
      logic [NC*BW-1:0] r;
      for (int c = 0; c < NC; c++) r[c*BW +: BW] = BW'($urandom);
      return r;
   endfunction

   // Model: a row pops only if every lane queue holds data; a write lands if there is room after the pop.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < NC; c++) mq[c].delete();
         exp_out = '0;
         exp_vld = 1'b0;
         exp_ovf = '0;
      end else begin
         bit pop_m;
         pop_m = rd;
         for (int c = 0; c < NC; c++) if (mq[c].size() == 0) pop_m = 1'b0;
         exp_vld = pop_m;
         if (pop_m) for (int c = 0; c < NC; c++) exp_out[c*BW +: BW] = mq[c].pop_front();
         for (int c = 0; c < NC; c++) begin
            if (wr[c]) begin
               if (mq[c].size() < DP) mq[c].push_back(din[c*BW +: BW]);
               else exp_ovf[c] = 1'b1;
            end
         end
      end
   end

   // Compare every cycle on the falling edge.
   always @(negedge clk) begin
      bit vld_m, full_m;
      vld_m  = 1'b1;
      full_m = 1'b0;
      for (int c = 0; c < NC; c++) begin
         if (mq[c].size() == 0)  vld_m  = 1'b0;
         if (mq[c].size() == DP) full_m = 1'b1;
      end
      chk("o_valid", NC*BW'(o_valid), NC*BW'(vld_m));
      chk("o_full", NC*BW'(o_full), NC*BW'(full_m));
      chk("o_ready", NC*BW'(o_ready), NC*BW'(!full_m));
      chk("o_out_vld", NC*BW'(o_out_vld), NC*BW'(exp_vld));
      chk("out", dout, exp_out);
      chk("o_overflow", NC*BW'(o_overflow), NC*BW'(exp_ovf));
      if (o_out_vld === 1'b1) pulses++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      reset = 1'b0;
      #2;
      reset = 1'b1;
   endtask

   initial begin
      logic [7:0]       kd [NC][NC];
      logic [7:0]       qd [NC][NC];
      logic [NC*BW-1:0] exp_row;
      int               p0;

      // Reset state, mid-stream reset after three rows
      tick();
      tick();
      reset = 1'b1;
      wr = '1;
      for (int r = 0; r < 3; r++) begin
         din = row_rand();
         tick();
      end
      wr = '0;
      rd = 1'b1;
      tick();
      rd = 1'b0;
      reset = 1'b0;
      #1;
      chk("rst_valid", NC*BW'(o_valid), '0);
      chk("rst_ready", NC*BW'(o_ready), NC*BW'(1));
      chk("rst_out", dout, '0);
      chk("rst_ovf", NC*BW'(o_overflow), '0);
      #1;
      reset = 1'b1;
      rd = 1'b1;
      tick();
      chk("rst_rd_vld", NC*BW'(o_out_vld), '0);
      rd = 1'b0;

      // Skewed single row: lane c written at cycle c
      for (int c = 0; c < NC; c++) begin
         chk("skew_valid_low", NC*BW'(o_valid), '0);
         wr = '0;
         wr[c] = 1'b1;
         din = row_val(100);
         tick();
      end
      wr = '0;
      chk("skew_valid_high", NC*BW'(o_valid), NC*BW'(1));
      rd = 1'b1;
      tick();
      rd = 1'b0;
      chk("skew_out", dout, row_val(100));
      chk("skew_vld", NC*BW'(o_out_vld), NC*BW'(1));
      tick();
      chk("skew_vld_once", NC*BW'(o_out_vld), '0);
      chk("skew_valid_after", NC*BW'(o_valid), '0);

      // Dot-product wavefront like mac_array: row q lane k written at cycle q+k, rd held high
      for (int a = 0; a < NC; a++)
         for (int i = 0; i < NC; i++) begin
            kd[a][i] = 8'($urandom);
            qd[a][i] = 8'($urandom);
         end
      p0 = pulses;
      rd = 1'b1;
      for (int t = 0; t < 2 * NC - 1; t++) begin
         wr = '0;
         din = '0;
         for (int k = 0; k < NC; k++) begin
            int q;
            int s;
            q = t - k;
            if (q >= 0 && q < NC) begin
               s = 0;
               for (int i = 0; i < NC; i++) s += int'(qd[q][i]) * int'(kd[k][i]);
               wr[k] = 1'b1;
               din[k*BW +: BW] = BW'(s);
            end
         end
         tick();
      end
      wr = '0;
      for (int i = 0; i < 30 && (pulses - p0) < NC; i++) tick();
      tick();
      chk("mac_pulses", NC*BW'(pulses - p0), NC*BW'(NC));
      rd = 1'b0;

      // Full and overflow: 17 rows, no reads
      for (int r = 0; r <= DP; r++) begin
         wr = '1;
         din = row_val(r * 16);
         tick();
         if (r == DP - 1) chk("full_after_16", NC*BW'(o_full), NC*BW'(1));
      end
      wr = '0;
      chk("ovf_all", NC*BW'(o_overflow), NC*BW'(8'hFF));
      rd = 1'b1;
      for (int r = 0; r < DP; r++) begin
         tick();
         chk("drain_row", dout, row_val(r * 16));
      end
      rd = 1'b0;
      tick();
      chk("row16_dropped", NC*BW'(o_valid), '0);

      // Simultaneous write and pop while full
      reset_pulse();
      wr = '1;
      for (int r = 0; r < DP; r++) begin
         din = row_val(200 + r * 8);
         tick();
      end
      din = row_const(555);
      rd = 1'b1;
      tick();
      wr = '0;
      chk("sim_pop", dout, row_val(200));
      chk("sim_full", NC*BW'(o_full), NC*BW'(1));
      chk("sim_no_ovf", NC*BW'(o_overflow), '0);
      for (int r = 0; r < DP; r++) tick();
      rd = 1'b0;
      exp_row = row_const(555);
      chk("sim_last", dout, exp_row);
      tick();
      chk("sim_empty", NC*BW'(o_valid), '0);

      // Wrap-around at steady occupancy 3
      wr = '1;
      for (int r = 0; r < 3; r++) begin
         din = row_rand();
         tick();
      end
      rd = 1'b1;
      for (int i = 0; i < 40; i++) begin
         din = row_rand();
         tick();
      end

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         wr = NC'($urandom);
         din = row_rand();
         rd = ($urandom_range(0, 3) != 0);
         tick();
      end
      wr = '0;
      rd = 1'b0;
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
